// File: rtl/lsu_pkg.sv
// Shared types and constants for the RV32I load/store unit and the decoder.
// Holds the FSM state type, byte-enable encodings and load/store opcodes.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Misaligned halves/words and unsupported enable patterns never reach the bus.
    function automatic logic access_bad(input logic [3:0] be, input logic [1:0] off);
        logic bad;
        case (be)
            BE_BYTE: bad = 1'b0;
            BE_HALF: bad = off[0];
            BE_WORD: bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Aligns a returned bus word to the accessed byte lane and applies
// sign or zero extension for byte, half and word loads.
module load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  offset_i,
    input  logic [3:0]  byte_en_i,
    input  logic        zero_ext_i,
    output logic [31:0] data_o
);

    logic [31:0]        shifted;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;

    assign shifted = word_i >> {offset_i, 3'b000};
    assign byte_s  = shifted[7:0];
    assign half_s  = shifted[15:0];

    always_comb begin
        data_o = shifted;
        case (byte_en_i)
            BE_BYTE: data_o = zero_ext_i ? {24'b0, shifted[7:0]} : 32'(byte_s);
            BE_HALF: data_o = zero_ext_i ? {16'b0, shifted[15:0]} : 32'(half_s);
            default: data_o = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: drives a req/ack data bus with lane-shifted enables
// and data, returns extended load data and stalls the pipeline while busy.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    input  logic        mem_wr_en_i,
    input  logic [3:0]  byte_en_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wr_data_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] load_data_o,
    output logic        misaligned_o,
    output logic        bus_err_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    lsu_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             mis_q, err_q, we_q;

    logic [31:0] addr_p1, wdata_p1, rdata_p2;
    logic [3:0]  be_p1, be_raw_p1;
    logic        zext_p1;

    logic        accept, bad_access, timeout_hit, in_req, in_done;
    logic [31:0] ext_data;
    logic        unused_f3;

    assign unused_f3   = ^funct3_i[1:0];
    assign accept      = (state_q == IDLE) && req_valid_i;
    assign bad_access  = access_bad(byte_en_i, addr_i[1:0]);
    assign timeout_hit = (state_q == REQ) && !bus_ack_i &&
                         (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid_i) state_d = bad_access ? DONE : REQ;
            REQ:     if (bus_ack_i || timeout_hit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mis_q   <= 1'b0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cnt_q <= '0;
                mis_q <= bad_access;
                err_q <= 1'b0;
                we_q  <= mem_wr_en_i;
            end else if (state_q == REQ && !bus_ack_i) begin
                cnt_q <= cnt_q + 1'b1;
                if (timeout_hit) err_q <= 1'b1;
            end
        end
    end

    // Request latch (p1) on accept; read data capture (p2) on ack.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            addr_p1   <= addr_i;
            be_raw_p1 <= byte_en_i;
            be_p1     <= byte_en_i << addr_i[1:0];
            wdata_p1  <= wr_data_i << {addr_i[1:0], 3'b000};
            zext_p1   <= funct3_i[2];
        end
        if (state_q == REQ && bus_ack_i) begin
            rdata_p2 <= bus_rdata_i;
        end
    end

    load_extend u_load_extend (
        .word_i     (rdata_p2),
        .offset_i   (addr_p1[1:0]),
        .byte_en_i  (be_raw_p1),
        .zero_ext_i (zext_p1),
        .data_o     (ext_data)
    );

    assign in_req  = (state_q == REQ);
    assign in_done = (state_q == DONE);

    // Bus outputs come straight from registers, gated to zero outside REQ.
    assign bus_req_o   = in_req;
    assign bus_we_o    = in_req & we_q;
    assign bus_addr_o  = in_req ? {addr_p1[31:2], 2'b00} : 32'b0;
    assign bus_be_o    = in_req ? be_p1 : 4'b0;
    assign bus_wdata_o = in_req ? wdata_p1 : 32'b0;

    assign busy_o       = (state_q != IDLE);
    assign done_o       = in_done;
    assign misaligned_o = in_done & mis_q;
    assign bus_err_o    = in_done & err_q;
    assign load_data_o  = (in_done && !we_q && !mis_q && !err_q) ? ext_data : 32'b0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a queue of expected completions.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, mem_wr_en, bus_ack;
    logic [3:0]  byte_en;
    logic [2:0]  funct3;
    logic [31:0] addr, wr_data, bus_rdata;
    logic        bus_req, bus_we, busy, done, misaligned, bus_err;
    logic [31:0] bus_addr, bus_wdata, load_data;
    logic [3:0]  bus_be;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] load;
        logic        mis;
        logic        err;
        int          lat;
        int          req_cycles;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .mem_wr_en_i  (mem_wr_en),
        .byte_en_i    (byte_en),
        .funct3_i     (funct3),
        .addr_i       (addr),
        .wr_data_i    (wr_data),
        .bus_req_o    (bus_req),
        .bus_we_o     (bus_we),
        .bus_addr_o   (bus_addr),
        .bus_be_o     (bus_be),
        .bus_wdata_o  (bus_wdata),
        .bus_ack_i    (bus_ack),
        .bus_rdata_i  (bus_rdata),
        .busy_o       (busy),
        .done_o       (done),
        .load_data_o  (load_data),
        .misaligned_o (misaligned),
        .bus_err_o    (bus_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Issue one access, ack on the (ack_dly+1)-th REQ cycle (never if negative),
    // and compare the completion against the queued expectation.
    task automatic run(input string tag, input logic we, input logic [3:0] be,
                       input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rd, input int ack_dly,
                       input logic [31:0] e_addr, input logic [3:0] e_be,
                       input logic [31:0] e_wd, input logic [31:0] e_load,
                       input logic e_mis, input logic e_err, input int e_lat,
                       input int e_req);
        exp_t e;
        int   lat;
        int   reqc;
        sb.push_back('{load: e_load, mis: e_mis, err: e_err, lat: e_lat, req_cycles: e_req});
        @(negedge clk);
        mem_wr_en = we; byte_en = be; funct3 = f3; addr = a; wr_data = wd;
        bus_rdata = rd; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        lat  = 1;
        reqc = 0;
        while (done !== 1'b1 && lat < 40) begin
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            if (bus_req === 1'b1) begin
                reqc++;
                chk({tag, "_addr"}, bus_addr, e_addr);
                chk({tag, "_be"}, 32'(bus_be), 32'(e_be));
                chk({tag, "_wdata"}, bus_wdata, e_wd);
                chk({tag, "_we"}, 32'(bus_we), 32'(we));
            end
            bus_ack = (ack_dly >= 0) && (reqc == ack_dly + 1);
            @(negedge clk);
            bus_ack = 1'b0;
            lat++;
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_lat"}, 32'(lat), 32'(e.lat));
            chk({tag, "_reqcyc"}, 32'(reqc), 32'(e.req_cycles));
            chk({tag, "_load"}, load_data, e.load);
            chk({tag, "_mis"}, 32'(misaligned), 32'(e.mis));
            chk({tag, "_err"}, 32'(bus_err), 32'(e.err));
            chk({tag, "_req_in_done"}, 32'(bus_req), 32'd0);
        end
        @(negedge clk);
        chk({tag, "_done_clr"}, 32'(done), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        bus_rdata = 32'h0;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; mem_wr_en = 1'b0; bus_ack = 1'b0;
        byte_en = 4'b0; funct3 = 3'b0; addr = 32'h0; wr_data = 32'h0; bus_rdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_req", 32'(bus_req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_load", load_data, 32'h0);
        chk("rst_flags", {30'b0, misaligned, bus_err}, 32'h0);
        chk("rst_bus", bus_addr | bus_wdata | 32'(bus_be) | 32'(bus_we), 32'h0);
        rst = 1'b0;

        // Stray ack while idle must not start anything.
        @(negedge clk);
        bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        chk("idle_ack_done", 32'(done), 32'd0);
        chk("idle_ack_busy", 32'(busy), 32'd0);

        run("sb",   1'b1, 4'b0001, 3'b000, 32'h103, 32'h0000_00AB, 32'h0, 1,
            32'h100, 4'b1000, 32'hAB00_0000, 32'h0, 1'b0, 1'b0, 3, 2);
        run("lb",   1'b0, 4'b0001, 3'b000, 32'h2, 32'h0, 32'h0080_0000, 0,
            32'h0, 4'b0100, 32'h0, 32'hFFFF_FF80, 1'b0, 1'b0, 2, 1);
        run("lbu",  1'b0, 4'b0001, 3'b100, 32'h2, 32'h0, 32'h0080_0000, 0,
            32'h0, 4'b0100, 32'h0, 32'h0000_0080, 1'b0, 1'b0, 2, 1);
        run("lh",   1'b0, 4'b0011, 3'b001, 32'h2, 32'h0, 32'h8001_0000, 0,
            32'h0, 4'b1100, 32'h0, 32'hFFFF_8001, 1'b0, 1'b0, 2, 1);
        run("lhu",  1'b0, 4'b0011, 3'b101, 32'h2, 32'h0, 32'h8001_0000, 0,
            32'h0, 4'b1100, 32'h0, 32'h0000_8001, 1'b0, 1'b0, 2, 1);
        run("lw",   1'b0, 4'b1111, 3'b010, 32'h0, 32'h0, 32'h8001_0000, 0,
            32'h0, 4'b1111, 32'h0, 32'h8001_0000, 1'b0, 1'b0, 2, 1);
        run("lb1",  1'b0, 4'b0001, 3'b000, 32'h1, 32'h0, 32'h0000_7F00, 0,
            32'h0, 4'b0010, 32'h0, 32'h0000_007F, 1'b0, 1'b0, 2, 1);
        run("sw",   1'b1, 4'b1111, 3'b010, 32'h44, 32'h1234_5678, 32'h0, 2,
            32'h44, 4'b1111, 32'h1234_5678, 32'h0, 1'b0, 1'b0, 4, 3);
        run("lw_mis", 1'b0, 4'b1111, 3'b010, 32'h6, 32'h0, 32'hDEAD_BEEF, 0,
            32'h0, 4'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1, 0);
        run("sh_mis", 1'b1, 4'b0011, 3'b001, 32'h1, 32'h0000_1234, 32'h0, 0,
            32'h0, 4'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1, 0);
        run("be_ill", 1'b0, 4'b0111, 3'b010, 32'h8, 32'h0, 32'h0, 0,
            32'h0, 4'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1, 0);
        run("lw_tmo", 1'b0, 4'b1111, 3'b010, 32'h20, 32'h0, 32'hCAFE_F00D, -1,
            32'h20, 4'b1111, 32'h0, 32'h0, 1'b0, 1'b1, 5, 4);

        // Reset in the middle of a request: bus drops at once, no completion follows.
        @(negedge clk);
        mem_wr_en = 1'b0; byte_en = 4'b1111; funct3 = 3'b010; addr = 32'h10;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rstreq_req_before", 32'(bus_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rstreq_req_drop", 32'(bus_req), 32'd0);
        chk("rstreq_busy", 32'(busy), 32'd0);
        chk("rstreq_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus_ack = 1'b1;
        bus_rdata = 32'h5555_AAAA;
        @(negedge clk);
        bus_ack = 1'b0;
        chk("rstreq_late_ack_done", 32'(done), 32'd0);
        chk("rstreq_late_ack_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("rstreq_quiet_done", 32'(done), 32'd0);
        chk("rstreq_quiet_req", 32'(bus_req), 32'd0);

        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
